// File: rtl/execute_muldiv_pkg.sv
// Shared types for the execute-stage multiply/divide unit: funct3 op codes,
// FSM states and the reset value of the control register.
package execute_muldiv_pkg;

    // Wide enough for XLEN/DIV_BITS-1 and any sensible MUL_LATENCY-1.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_type;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_type;

    typedef struct packed {
        muldiv_state_type  state;
        muldiv_op_type     op;
        logic [CNT_W-1:0]  cnt;
        logic              neg_q;
        logic              neg_r;
    } muldiv_reg_type;

    localparam muldiv_reg_type init_muldiv_reg = '{
        state: IDLE,
        op:    OP_MUL,
        cnt:   '0,
        neg_q: 1'b0,
        neg_r: 1'b0
    };

endpackage

// File: rtl/execute_muldiv_div_step.sv
// One radix-2^DIV_BITS restoring division step on unsigned magnitudes.
// Dividend bits are consumed MSB first; quotient bits come out MSB first.
module execute_muldiv_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0]     rem_in,
    input  logic [XLEN-1:0]     divisor,
    input  logic [DIV_BITS-1:0] bits,
    output logic [DIV_BITS-1:0] q_bits,
    output logic [XLEN-1:0]     rem_out
);

    logic [XLEN:0] r;

    always_comb begin
        r      = {1'b0, rem_in};
        q_bits = '0;
        for (int i = DIV_BITS - 1; i >= 0; i--) begin
            // r < divisor before the shift, so one extra bit holds 2*r+1.
            r = {r[XLEN-1:0], bits[i]};
            if (r >= {1'b0, divisor}) begin
                r         = r - {1'b0, divisor};
                q_bits[i] = 1'b1;
            end
        end
        rem_out = r[XLEN-1:0];
    end

endmodule

// File: rtl/execute_muldiv.sv
// Long-latency M-extension unit: pipelined-latency multiply and iterative
// restoring divide with sign fix-up; kill aborts any in-flight operation.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_BITS    = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] result,
    output logic            ready,
    output logic            busy
);

    localparam int              DIV_ITER = XLEN / DIV_BITS;
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_reg_type ctrl;

    logic [2*XLEN-1:0]  product;
    logic [2*XLEN-1:0]  product_next;
    logic [XLEN-1:0]    rem;
    logic [XLEN-1:0]    quo;
    logic [XLEN-1:0]    dsr;
    logic [XLEN-1:0]    rem_step;
    logic [DIV_BITS-1:0] q_step;

    logic            a_signed;
    logic            b_signed;
    logic [XLEN:0]   mul_a;
    logic [XLEN:0]   mul_b;
    logic            div_signed;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] div_special;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] sel,
                                                 input logic [2*XLEN-1:0] p);
        return (sel == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        a_signed   = (op == OP_MULH) || (op == OP_MULHSU);
        b_signed   = (op == OP_MULH);
        mul_a      = {a_signed & rdata1[XLEN-1], rdata1};
        mul_b      = {b_signed & rdata2[XLEN-1], rdata2};
        // Low 2*XLEN bits of the product of the XLEN+1-bit extended operands.
        product_next = {{(XLEN-1){mul_a[XLEN]}}, mul_a}
                     * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

        div_signed  = ~op[0];
        div_zero    = (rdata2 == '0);
        div_ovf     = div_signed && (rdata1 == MIN_INT) && (rdata2 == '1);
        div_special = div_zero ? (op[1] ? rdata1 : '1)
                               : (op[1] ? '0 : MIN_INT);
        a_mag       = (div_signed && rdata1[XLEN-1]) ? -rdata1 : rdata1;
        b_mag       = (div_signed && rdata2[XLEN-1]) ? -rdata2 : rdata2;

        quo_fixed   = ctrl.neg_q ? -quo : quo;
        rem_fixed   = ctrl.neg_r ? -rem : rem;
    end

    execute_muldiv_div_step #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .rem_in  (rem),
        .divisor (dsr),
        .bits    (quo[XLEN-1 -: DIV_BITS]),
        .q_bits  (q_step),
        .rem_out (rem_step)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl    <= init_muldiv_reg;
            result  <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            product <= '0;
            rem     <= '0;
            quo     <= '0;
            dsr     <= '0;
        end else if (kill) begin
            ctrl.state <= IDLE;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (ctrl.state)
                IDLE, DONE: begin
                    if (start) begin
                        ctrl.op <= muldiv_op_type'(op);
                        busy    <= 1'b1;
                        if (!op[2]) begin
                            product <= product_next;
                            if (MUL_LATENCY == 1) begin
                                ctrl.state <= DONE;
                                result     <= mul_pick(op, product_next);
                                ready      <= 1'b1;
                            end else begin
                                ctrl.state <= MUL;
                                ctrl.cnt   <= CNT_W'(MUL_LATENCY - 1);
                            end
                        end else if (div_zero || div_ovf) begin
                            ctrl.state <= DONE;
                            result     <= div_special;
                            ready      <= 1'b1;
                        end else begin
                            ctrl.state <= DIV;
                            ctrl.cnt   <= CNT_W'(DIV_ITER - 1);
                            ctrl.neg_q <= div_signed & (rdata1[XLEN-1] ^ rdata2[XLEN-1]);
                            ctrl.neg_r <= div_signed & rdata1[XLEN-1];
                            rem        <= '0;
                            quo        <= a_mag;
                            dsr        <= b_mag;
                        end
                    end else begin
                        ctrl.state <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                MUL: begin
                    // Leave while the count steps to zero so DONE lands on cycle MUL_LATENCY.
                    if (ctrl.cnt == CNT_W'(1)) begin
                        ctrl.state <= DONE;
                        result     <= mul_pick(ctrl.op, product);
                        ready      <= 1'b1;
                    end
                    ctrl.cnt <= ctrl.cnt - CNT_W'(1);
                end
                DIV: begin
                    rem      <= rem_step;
                    quo      <= {quo[XLEN-DIV_BITS-1:0], q_step};
                    ctrl.cnt <= ctrl.cnt - CNT_W'(1);
                    if (ctrl.cnt == '0) begin
                        ctrl.state <= FIX;
                    end
                end
                FIX: begin
                    ctrl.state <= DONE;
                    result     <= ctrl.op[1] ? rem_fixed : quo_fixed;
                    ready      <= 1'b1;
                end
                default: begin
                    ctrl.state <= IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
